// File: rtl/spi_rx_pkg.sv
// spi_rx_pkg: shared state encoding, constants and width helper for the
// SPI return-data router (spi_rx_router and spi_rx_shifter).
package spi_rx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    // sel value meaning "no slave selected"
    localparam int unsigned SEL_IDLE = 32'd0;

    // Bits needed to hold any count from 0 up to and including max_val
    function automatic int cnt_width(input int max_val);
        if (max_val < 32'sd2) begin
            return 32'sd1;
        end else begin
            return $clog2(max_val + 32'sd1);
        end
    endfunction

endpackage

// File: rtl/spi_rx_shifter.sv
// spi_rx_shifter: MSB-first deserialiser with a saturating bit counter.
// Once DATA_W bits have been taken, further bits are dropped so the word
// always holds the first DATA_W bits of the transfer.
module spi_rx_shifter
    import spi_rx_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              shift_en,
    input  logic              bit_in,
    output logic [DATA_W-1:0] word,
    output logic              full
);

    localparam int CNT_W = cnt_width(DATA_W);

    logic [DATA_W-1:0] shreg_r;
    logic [CNT_W-1:0]  count_r;
    logic              full_s;

    assign full_s = (count_r == CNT_W'(DATA_W));

    // Shift register and bit counter; clear wins over a shift in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_r <= '0;
            count_r <= '0;
        end else if (clear) begin
            shreg_r <= '0;
            count_r <= '0;
        end else if (shift_en && !full_s) begin
            shreg_r <= {shreg_r[DATA_W-2:0], bit_in};
            count_r <= count_r + CNT_W'(1);
        end else begin
            shreg_r <= shreg_r;
            count_r <= count_r;
        end
    end

    assign word = shreg_r;
    assign full = full_s;

endmodule

// File: rtl/spi_rx_router.sv
// spi_rx_router: steers the SPI MISO word of the selected slave into a
// per-channel output register with a valid/ack handshake and sticky overrun.
// Optional capture watchdog: define SPI_RX_TIMEOUT_EN to enable it; without
// it CAPTURE waits for done indefinitely and timeout_err stays 0.
module spi_rx_router
    import spi_rx_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int DATA_W      = 8,
    parameter int SEL_W       = 3,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     bit_valid,
    input  logic                     bit_in,
    input  logic                     done,
    input  logic [N_CH-1:0]          ch_ack,
    output logic [N_CH*DATA_W-1:0]   ch_data,
    output logic [N_CH-1:0]          ch_valid,
    output logic [N_CH-1:0]          overrun,
    output logic                     short_err,
    output logic                     timeout_err,
    output logic                     busy
);

    state_t                        state_r;
    state_t                        state_nxt_s;
    logic [SEL_W-1:0]              ch_id_r;
    logic                          sel_ok_s;
    logic                          latch_id_s;
    logic                          shift_clear_s;
    logic                          shift_en_s;
    logic                          commit_s;
    logic                          short_pulse_s;
    logic                          tmo_pulse_s;
    logic                          tmo_hit_s;
    logic [DATA_W-1:0]             word_s;
    logic                          full_s;
    logic [N_CH-1:0][DATA_W-1:0]   ch_data_r;
    logic [N_CH-1:0]               ch_valid_r;
    logic [N_CH-1:0]               overrun_r;
    logic                          short_err_r;
    logic                          timeout_err_r;

    assign sel_ok_s = (sel != SEL_W'(SEL_IDLE)) && (sel <= SEL_W'(N_CH));

    spi_rx_shifter #(
        .DATA_W (DATA_W)
    ) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .clear    (shift_clear_s),
        .shift_en (shift_en_s),
        .bit_in   (bit_in),
        .word     (word_s),
        .full     (full_s)
    );

`ifdef SPI_RX_TIMEOUT_EN
    localparam int TMO_W = cnt_width(TIMEOUT_CYC);

    logic [TMO_W-1:0] tmo_cnt_r;

    // A bit on the expiry cycle restarts the idle window instead of aborting
    assign tmo_hit_s = (state_r == CAPTURE) && !bit_valid &&
                       (tmo_cnt_r == TMO_W'(TIMEOUT_CYC - 32'sd1));

    // Idle-cycle watchdog: counts CAPTURE cycles since the last received bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_r <= '0;
        end else if ((state_r != CAPTURE) || bit_valid) begin
            tmo_cnt_r <= '0;
        end else if (!tmo_hit_s) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end
`else
    assign tmo_hit_s = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state; done beats a watchdog expiry in the same cycle
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (sel_ok_s) begin
                    state_nxt_s = CAPTURE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CAPTURE: begin
                if (done) begin
                    state_nxt_s = COMMIT;
                end else if (tmo_hit_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = CAPTURE;
                end
            end
            COMMIT:  state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM control outputs; a bit arriving with done is still shifted in
    always_comb begin
        latch_id_s    = 1'b0;
        shift_clear_s = 1'b0;
        shift_en_s    = 1'b0;
        commit_s      = 1'b0;
        short_pulse_s = 1'b0;
        tmo_pulse_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (sel_ok_s) begin
                    latch_id_s    = 1'b1;
                    shift_clear_s = 1'b1;
                end else begin
                    latch_id_s    = 1'b0;
                    shift_clear_s = 1'b0;
                end
            end
            CAPTURE: begin
                shift_en_s  = bit_valid;
                tmo_pulse_s = tmo_hit_s && !done;
            end
            COMMIT: begin
                if (full_s) begin
                    commit_s = 1'b1;
                end else begin
                    short_pulse_s = 1'b1;
                end
            end
            default: begin
                commit_s = 1'b0;
            end
        endcase
    end

    // Channel id latched when a transfer starts; sel is ignored afterwards
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_id_r <= '0;
        end else if (latch_id_s) begin
            ch_id_r <= sel - SEL_W'(1);
        end else begin
            ch_id_r <= ch_id_r;
        end
    end

    // Per-channel word registers, valid/ack handshake and sticky overrun
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_data_r  <= '0;
            ch_valid_r <= '0;
            overrun_r  <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (commit_s && (ch_id_r == SEL_W'(i))) begin
                    ch_data_r[i]  <= word_s;
                    ch_valid_r[i] <= 1'b1;
                    if (ch_valid_r[i] && !ch_ack[i]) begin
                        overrun_r[i] <= 1'b1;
                    end else if (ch_ack[i]) begin
                        overrun_r[i] <= 1'b0;
                    end else begin
                        overrun_r[i] <= overrun_r[i];
                    end
                end else if (ch_ack[i]) begin
                    ch_valid_r[i] <= 1'b0;
                    overrun_r[i]  <= 1'b0;
                end else begin
                    ch_valid_r[i] <= ch_valid_r[i];
                    overrun_r[i]  <= overrun_r[i];
                end
            end
        end
    end

    // One-cycle error pulses, registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            short_err_r   <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            short_err_r   <= short_pulse_s;
            timeout_err_r <= tmo_pulse_s;
        end
    end

    assign ch_data     = ch_data_r;
    assign ch_valid    = ch_valid_r;
    assign overrun     = overrun_r;
    assign short_err   = short_err_r;
    assign timeout_err = timeout_err_r;
    assign busy        = (state_r != IDLE);

endmodule

// File: tb/tb_spi_rx_router.sv
// tb_spi_rx_router: directed self-checking bench for spi_rx_router
// (N_CH=4, DATA_W=8, TIMEOUT_CYC=16). Inputs change on the falling edge,
// outputs are sampled on the falling edge.
module tb_spi_rx_router;

    localparam int N_CH        = 4;
    localparam int DATA_W      = 8;
    localparam int SEL_W       = 3;
    localparam int TIMEOUT_CYC = 16;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [SEL_W-1:0]       sel;
    logic                   bit_valid;
    logic                   bit_in;
    logic                   done;
    logic [N_CH-1:0]        ch_ack;
    logic [N_CH*DATA_W-1:0] ch_data;
    logic [N_CH-1:0]        ch_valid;
    logic [N_CH-1:0]        overrun;
    logic                   short_err;
    logic                   timeout_err;
    logic                   busy;

    int checks = 0;
    int errors = 0;
    int tmo_seen;

    always #5 clk = ~clk;

    spi_rx_router #(
        .N_CH        (N_CH),
        .DATA_W      (DATA_W),
        .SEL_W       (SEL_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sel         (sel),
        .bit_valid   (bit_valid),
        .bit_in      (bit_in),
        .done        (done),
        .ch_ack      (ch_ack),
        .ch_data     (ch_data),
        .ch_valid    (ch_valid),
        .overrun     (overrun),
        .short_err   (short_err),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full transfer: select, n bits MSB-first from val, done (merged with the
    // last bit if merge), ack driven during the COMMIT cycle. Returns at the
    // falling edge just after the commit edge.
    task automatic xfer(input logic [SEL_W-1:0] s, input logic [15:0] val, input int n,
                        input logic merge, input logic [N_CH-1:0] ack);
        @(negedge clk);
        sel = s; bit_valid = 1'b0; done = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bit_valid = 1'b1;
            bit_in    = val[n-1-i];
            if (merge && (i == n - 1)) begin
                done = 1'b1;
                sel  = '0;
            end
        end
        if (!merge) begin
            @(negedge clk);
            bit_valid = 1'b0; done = 1'b1; sel = '0;
        end
        @(negedge clk);
        bit_valid = 1'b0; done = 1'b0; ch_ack = ack;
        @(negedge clk);
        ch_ack = '0;
    endtask

    initial begin
        rst = 1'b1; sel = '0; bit_valid = 1'b0; bit_in = 1'b0; done = 1'b0; ch_ack = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_valid",   ch_valid,    32'h0);
        chk("rst_data",    ch_data,     32'h0);
        chk("rst_overrun", overrun,     32'h0);
        chk("rst_short",   short_err,   32'h0);
        chk("rst_tmo",     timeout_err, 32'h0);
        chk("rst_busy",    busy,        32'h0);

        // Full word 0xA5 to slave 2
        xfer(3'd2, 16'h00A5, 8, 1'b0, 4'b0000);
        chk("a5_valid", ch_valid,  32'h2);
        chk("a5_data",  ch_data,   32'h0000A500);
        chk("a5_short", short_err, 32'h0);
        chk("a5_ovr",   overrun,   32'h0);
        chk("a5_busy",  busy,      32'h0);
        ch_ack = 4'b0010;
        @(negedge clk);
        ch_ack = '0;
        chk("a5_ack_valid", ch_valid, 32'h0);

        // Short transfer: 5 bits to slave 3
        xfer(3'd3, 16'h0016, 5, 1'b0, 4'b0000);
        chk("short_pulse", short_err, 32'h1);
        chk("short_valid", ch_valid,  32'h0);
        chk("short_data",  ch_data,   32'h0000A500);
        @(negedge clk);
        chk("short_end", short_err, 32'h0);

        // Overrun: two words to slave 1 without ack
        xfer(3'd1, 16'h003C, 8, 1'b0, 4'b0000);
        chk("ovr1_data", ch_data, 32'h0000A53C);
        chk("ovr1_ovr",  overrun, 32'h0);
        xfer(3'd1, 16'h00C3, 8, 1'b0, 4'b0000);
        chk("ovr2_data",  ch_data,  32'h0000A5C3);
        chk("ovr2_ovr",   overrun,  32'h1);
        chk("ovr2_valid", ch_valid, 32'h1);
        ch_ack = 4'b0001;
        @(negedge clk);
        ch_ack = '0;
        chk("ovr_ack_valid", ch_valid, 32'h0);
        chk("ovr_ack_ovr",   overrun,  32'h0);

        // Invalid and idle selects with toggling bit_valid and stray done
        sel = 3'd5;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) sel = 3'd0;
            bit_valid = i[0];
            bit_in    = i[1];
            done      = (i == 5) || (i == 15);
            @(negedge clk);
            chk("idle_busy", busy, 32'h0);
        end
        bit_valid = 1'b0; done = 1'b0;
        @(negedge clk);
        chk("idle_valid", ch_valid,  32'h0);
        chk("idle_data",  ch_data,   32'h0000A5C3);
        chk("idle_ovr",   overrun,   32'h0);
        chk("idle_short", short_err, 32'h0);

        // Commit and ack colliding on channel 4
        xfer(3'd4, 16'h005A, 8, 1'b0, 4'b0000);
        chk("c4a_valid", ch_valid, 32'h8);
        chk("c4a_data",  ch_data,  32'h5A00A5C3);
        xfer(3'd4, 16'h0081, 8, 1'b0, 4'b1000);
        chk("c4b_valid", ch_valid, 32'h8);
        chk("c4b_ovr",   overrun,  32'h0);
        chk("c4b_data",  ch_data,  32'h8100A5C3);

        // More than DATA_W bits: first 8 of 1100110011 kept
        xfer(3'd1, 16'h0333, 10, 1'b0, 4'b0000);
        chk("long_data",  ch_data,  32'h8100A5CC);
        chk("long_valid", ch_valid, 32'h9);
        chk("long_ovr",   overrun,  32'h0);

        // Last bit and done in the same cycle
        xfer(3'd3, 16'h0096, 8, 1'b1, 4'b0000);
        chk("merge_data",  ch_data,   32'h8196A5CC);
        chk("merge_valid", ch_valid,  32'hD);
        chk("merge_short", short_err, 32'h0);

        // Asynchronous reset in the middle of a transfer
        @(negedge clk);
        sel = 3'd2;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bit_valid = 1'b1; bit_in = 1'b1;
        end
        @(negedge clk);
        bit_valid = 1'b0;
        chk("mid_busy", busy, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy",  busy,     32'h0);
        chk("arst_valid", ch_valid, 32'h0);
        chk("arst_data",  ch_data,  32'h0);
        chk("arst_ovr",   overrun,  32'h0);
        @(negedge clk);
        sel = '0;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy",  busy,     32'h0);
        chk("post_rst_valid", ch_valid, 32'h0);

`ifdef SPI_RX_TIMEOUT_EN
        // Watchdog: 3 bits then silence
        @(negedge clk);
        sel = 3'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bit_valid = 1'b1; bit_in = 1'b1;
        end
        @(negedge clk);
        bit_valid = 1'b0; sel = '0;
        tmo_seen = 0;
        for (int k = 1; (k <= 40) && (tmo_seen == 0); k++) begin
            @(negedge clk);
            if (timeout_err) tmo_seen = k;
        end
        chk("tmo_latency", tmo_seen, 32'd16);
        chk("tmo_busy",    busy,     32'h0);
        chk("tmo_valid",   ch_valid, 32'h0);
        @(negedge clk);
        chk("tmo_pulse_end", timeout_err, 32'h0);
`else
        // No watchdog: a stalled capture waits for done
        @(negedge clk);
        sel = 3'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bit_valid = 1'b1; bit_in = 1'b1;
        end
        @(negedge clk);
        bit_valid = 1'b0; sel = '0;
        repeat (40) @(negedge clk);
        chk("stall_busy", busy,        32'h1);
        chk("stall_tmo",  timeout_err, 32'h0);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        @(negedge clk);
        chk("stall_short", short_err, 32'h1);
        chk("stall_valid", ch_valid,  32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
